ifu_fetch: RTL and testbench

//   Instruction fetch unit: the producer feeding the decode stage. Holds the PC, issues word

---
 rtl/ifu_fetch.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, req/gnt/rvalid fetch port, response FIFO and decode handshake.
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt_o / stall_cnt_o performance counters.
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, resp_pc_q, jump_target;
  logic [CW-1:0] out_cnt_q, drop_cnt_q, fifo_cnt_q;
  logic [CW-1:0] out_cnt_d, drop_cnt_d, fifo_cnt_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_addr [FIFO_DEPTH];
  logic          gnt, push, pop;

  assign jump_target = jump_addr_i & 32'hFFFF_FFFC;
  assign mem_addr_o  = pc_q;
  assign gnt         = mem_req_o & mem_gnt_i;
  // Responses owed to an abandoned stream are discarded until drop_cnt runs out.
  assign push        = mem_rvalid_i & ~jump_en_i & (drop_cnt_q == '0);
  assign pop         = inst_valid_o & inst_ready_i & ~jump_en_i;

  // A grant in the jump cycle belongs to the old stream; an rvalid in it is dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CW'(gnt) - CW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    if (jump_en_i) begin
      drop_cnt_d = drop_cnt_q + out_cnt_q + CW'(gnt) - CW'(mem_rvalid_i);
      out_cnt_d  = '0;
      fifo_cnt_d = '0;
    end else if (mem_rvalid_i && drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (jump_en_i && drop_cnt_d != '0) state_d = S_DRAIN;
      S_DRAIN: if (drop_cnt_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    mem_req_o    = 1'b0;
    inst_valid_o = 1'b0;
    inst_o       = NOP;
    inst_addr_o  = 32'h0;
    if (state_q == S_RUN && (out_cnt_q + fifo_cnt_q) < DEPTH_C) mem_req_o = 1'b1;
    if (fifo_cnt_q != '0) begin
      inst_valid_o = 1'b1;
      inst_o       = fifo_inst[rd_ptr_q];
      inst_addr_o  = fifo_addr[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (jump_en_i) begin
        pc_q      <= jump_target;
        resp_pc_q <= jump_target;
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
      end else begin
        if (gnt) pc_q <= pc_q + 32'd4;
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
          wr_ptr_q  <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; fifo_cnt_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= mem_rdata_i;
      fifo_addr[wr_ptr_q] <= resp_pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o <= 32'h0;
      stall_cnt_o <= 32'h0;
    end else begin
      if (inst_valid_o && inst_ready_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (state_q == S_RUN && !inst_valid_o) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  // Credit rule guarantees these never fire with a well-behaved memory.
  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (fifo_cnt_q != DEPTH_C || pop));
  a_out_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    gnt |-> (out_cnt_q != DEPTH_C));
  a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid_i |-> (out_cnt_q != '0 || drop_cnt_q != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: transaction-level model of streams, directed scenarios
// followed by randomized grant/latency/ready/jump traffic.
module tb_ifu_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] NONE  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, jump_en_i, inst_valid_o, inst_ready_i;
  logic [31:0] mem_addr_o, mem_rdata_i, jump_addr_i, inst_o, inst_addr_o;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  typedef struct packed {logic [31:0] addr; logic stale;} fl_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} ent_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] due;} mreq_t;
  typedef enum {M_BOOT, M_RUN, M_DRAIN} mstate_t;

  // Reference model: fetches in flight (tagged old/new stream) and words awaiting decode.
  fl_t         m_infl[$];
  ent_t        m_fifo[$];
  mstate_t     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_fetch, m_stall;
  // Memory emulator queue and observation logs.
  mreq_t       mq[$];
  logic [31:0] granted[$];
  logic [31:0] delivered[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          gnt_pct, rdy_pct, lat_min, lat_max, jmp_pct, trig;
  logic [31:0] trig_addr;
  bit          last_jump;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_iaddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return NONE;
  endfunction

  task automatic model_reset();
    m_infl.delete();
    m_fifo.delete();
    mq.delete();
    granted.delete();
    delivered.delete();
    m_state   = M_BOOT;
    m_pc      = 32'h0;
    m_fetch   = 32'h0;
    m_stall   = 32'h0;
    trig      = 0;
    last_jump = 1'b0;
  endtask

  task automatic model_update(input logic req, input logic gnt, input logic rvalid,
                              input logic ready, input logic jump, input logic [31:0] jt);
    fl_t f;
    bit  any_stale;
    if (m_fifo.size() != 0 && ready) m_fetch++;
    if (m_state == M_RUN && m_fifo.size() == 0) m_stall++;
    if (!jump && m_fifo.size() != 0 && ready) void'(m_fifo.pop_front());
    if (rvalid && m_infl.size() != 0) begin
      f = m_infl.pop_front();
      if (!jump && !f.stale) m_fifo.push_back(ent_t'{addr: f.addr, data: word_of(f.addr)});
    end
    if (req && gnt) begin
      m_infl.push_back(fl_t'{addr: m_pc, stale: jump});
      if (!jump) m_pc = m_pc + 32'd4;
    end
    if (jump) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_pc = {jt[31:2], 2'b00};
    end
    any_stale = 1'b0;
    foreach (m_infl[i]) if (m_infl[i].stale) any_stale = 1'b1;
    if (m_state == M_BOOT) m_state = M_RUN;
    else                   m_state = any_stale ? M_DRAIN : M_RUN;
  endtask

  // One cycle: compare at the falling edge, drive inputs, advance the model.
  task automatic step();
    int          new_cnt, lat;
    logic        e_req, d_gnt, d_rvalid, d_ready, do_jump;
    logic [31:0] d_rdata, jt, due;
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_valid = inst_valid_o;
    s_inst  = inst_o;
    s_iaddr = inst_addr_o;
    new_cnt = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) new_cnt++;
    e_req = (m_state == M_RUN) && ((new_cnt + m_fifo.size()) < DEPTH);
    check("mem_req", {31'b0, s_req}, {31'b0, e_req});
    check("mem_addr", s_addr, m_pc);
    check("inst_valid", {31'b0, s_valid}, {31'b0, m_fifo.size() != 0});
    check("inst", s_inst, (m_fifo.size() != 0) ? m_fifo[0].data : NOP);
    check("inst_addr", s_iaddr, (m_fifo.size() != 0) ? m_fifo[0].addr : 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt_o, m_fetch);
    check("stall_cnt", stall_cnt_o, m_stall);
`endif
    d_gnt = ($urandom_range(99) < gnt_pct);
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      d_rvalid = 1'b1;
      d_rdata  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      d_rvalid = 1'b0;
      d_rdata  = $urandom;
    end
    d_ready = ($urandom_range(99) < rdy_pct);
    do_jump = 1'b0;
    jt      = $urandom;
    case (trig)
      1: do_jump = (mq.size() == 2 && !d_rvalid);
      2: do_jump = (s_req && d_gnt && d_rvalid);
      3: do_jump = 1'b1;
      default: do_jump = 1'b0;
    endcase
    if (do_jump) begin
      jt   = trig_addr;
      trig = 0;
    end else if (!last_jump && $urandom_range(99) < jmp_pct) begin
      do_jump = 1'b1;
    end
    last_jump    = do_jump;
    mem_gnt_i    = d_gnt;
    mem_rvalid_i = d_rvalid;
    mem_rdata_i  = d_rdata;
    inst_ready_i = d_ready;
    jump_en_i    = do_jump;
    jump_addr_i  = jt;
    if (s_req && d_gnt) begin
      granted.push_back(s_addr);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (mq.size() != 0 && mq[$].due >= due) due = mq[$].due + 1;
      mq.push_back(mreq_t'{addr: s_addr, due: due});
    end
    if (s_valid && d_ready && !do_jump) delivered.push_back(s_iaddr);
    model_update(e_req, d_gnt, d_rvalid, d_ready, do_jump, jt);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    inst_ready_i = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, mem_req_o}, 32'h0);
    check({tag, "_addr"}, mem_addr_o, 32'h0);
    check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'h0);
    check({tag, "_inst"}, inst_o, NOP);
    check({tag, "_iaddr"}, inst_addr_o, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic knobs(input int g, input int r, input int lmin, input int lmax, input int j);
    gnt_pct = g;
    rdy_pct = r;
    lat_min = lmin;
    lat_max = lmax;
    jmp_pct = j;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    knobs(100, 100, 1, 1, 0);

    // Streaming with gnt tied high and one-cycle latency.
    do_reset();
    step();
    check("boot_no_req", {31'b0, s_req}, 32'h0);
    step();
    check("first_req", {31'b0, s_req}, 32'h1);
    check("first_addr", s_addr, 32'h0);
    repeat (20) step();
    check("t1_d0", qget(delivered, 0), 32'h0);
    check("t1_d1", qget(delivered, 1), 32'h4);
    check("t1_d2", qget(delivered, 2), 32'h8);

    // Decode stalled: credits cap grants at FIFO_DEPTH.
    do_reset();
    knobs(100, 0, 1, 1, 0);
    repeat (12) step();
    check("t2_grants", granted.size(), 32'd2);
    check("t2_req_low", {31'b0, s_req}, 32'h0);
    check("t2_head", s_iaddr, 32'h0);
    knobs(100, 100, 1, 1, 0);
    repeat (10) step();
    check("t2_d0", qget(delivered, 0), 32'h0);
    check("t2_d1", qget(delivered, 1), 32'h4);
    check("t2_resume", qget(granted, 2), 32'h8);

    // Jump with two fetches in flight: both responses are dropped.
    do_reset();
    knobs(100, 100, 5, 5, 0);
    trig      = 1;
    trig_addr = 32'h0000_0100;
    repeat (4) step();
    check("t3_fired", trig, 0);
    step();
    check("t3_drain_req", {31'b0, s_req}, 32'h0);
    repeat (20) step();
    check("t3_grant", qget(granted, 2), 32'h100);
    check("t3_d0", qget(delivered, 0), 32'h100);

    // Jump coinciding with gnt and rvalid, unaligned target.
    do_reset();
    knobs(100, 100, 1, 1, 0);
    trig      = 2;
    trig_addr = 32'h0000_0203;
    repeat (3) step();
    check("t4_fired", trig, 0);
    step();
    check("t4_drain_req", {31'b0, s_req}, 32'h0);
    repeat (15) step();
    check("t4_grant", qget(granted, 2), 32'h200);
    check("t4_d0", qget(delivered, 0), 32'h200);

    // PC wrap at the top of the address space, redirect issued in S_BOOT.
    do_reset();
    knobs(100, 100, 1, 3, 0);
    trig      = 3;
    trig_addr = 32'hFFFF_FFF8;
    repeat (30) step();
    check("t5_g0", qget(granted, 0), 32'hFFFF_FFF8);
    check("t5_g1", qget(granted, 1), 32'hFFFF_FFFC);
    check("t5_g2", qget(granted, 2), 32'h0000_0000);
    check("t5_g3", qget(granted, 3), 32'h0000_0004);
    check("t5_d2", qget(delivered, 2), 32'h0000_0000);

    // Asynchronous reset with a full buffer.
    do_reset();
    knobs(100, 0, 1, 1, 0);
    repeat (10) step();
    check("t6_full_valid", {31'b0, s_valid}, 32'h1);
    check("t6_full_noreq", {31'b0, s_req}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    do_reset();
    knobs(100, 100, 1, 2, 0);
    repeat (10) step();

    // Randomized traffic with redirects.
    for (int seg = 0; seg < 6; seg++) begin
      if (seg == 3) do_reset();
      knobs($urandom_range(100, 30), $urandom_range(100, 20), 1, $urandom_range(4, 1), 5);
      repeat (400) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
